// File: rtl/frame_mismatch_counter.sv
// Per-frame byte-pair mismatch statistics: counts pairs, unequal pairs and
// differing bits over a valid/ready stream, then holds a result record.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input pair handshake
//   in_a, in_b, in_last        operands and early frame close
//   out_valid/out_ready        result record handshake
//   out_pairs, out_mismatch    saturating pair / unequal-pair counts
//   out_bit_errs               saturating sum of popcount(a ^ b)
//   out_all_equal              high when out_mismatch is zero
module frame_mismatch_counter #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8,
    parameter int ERR_W     = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_pairs,
    output logic [CNT_W-1:0] out_mismatch,
    output logic [ERR_W-1:0] out_bit_errs,
    output logic             out_all_equal
);

    // Frame position is tracked separately from the saturating pair count
    // so a frame still closes at FRAME_LEN when CNT_W is too narrow.
    localparam int IDX_W  = $clog2(FRAME_LEN + 1);
    localparam int PC_W   = $clog2(WIDTH + 1);
    localparam int ERR_W1 = ERR_W + 1;

    typedef enum logic {
        ACCUM,
        REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pairs_q, pairs_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [ERR_W-1:0] errs_q, errs_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [WIDTH-1:0]  diff;
    logic [PC_W-1:0]   pc;
    logic [ERR_W1-1:0] errs_sum;
    logic              accept;
    logic              frame_end;

    always_comb begin
        diff = in_a ^ in_b;
        pc   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(diff[i]);
        end
    end

    // Extra carry bit detects overflow of the bit-error accumulator.
    assign errs_sum  = {1'b0, errs_q} + ERR_W1'(pc);
    assign accept    = in_valid && (state_q == ACCUM);
    assign frame_end = accept &&
                       (in_last || (idx_q == IDX_W'(FRAME_LEN - 1)));

    always_comb begin
        state_d = state_q;
        pairs_d = pairs_q;
        mism_d  = mism_q;
        errs_d  = errs_q;
        idx_d   = idx_q;
        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (!(&pairs_q)) begin
                        pairs_d = pairs_q + CNT_W'(1);
                    end
                    if ((diff != '0) && !(&mism_q)) begin
                        mism_d = mism_q + CNT_W'(1);
                    end
                    errs_d = errs_sum[ERR_W] ? '1 : errs_sum[ERR_W-1:0];
                    if (frame_end) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    pairs_d = '0;
                    mism_d  = '0;
                    errs_d  = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            pairs_q <= '0;
            mism_q  <= '0;
            errs_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pairs_q <= pairs_d;
            mism_q  <= mism_d;
            errs_q  <= errs_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready      = (state_q == ACCUM);
    assign out_valid     = (state_q == REPORT);
    assign out_pairs     = pairs_q;
    assign out_mismatch  = mism_q;
    assign out_bit_errs  = errs_q;
    assign out_all_equal = (mism_q == '0);

endmodule

// File: tb/tb_frame_mismatch_counter.sv
// Directed self-checking bench for frame_mismatch_counter.
// Second instance uses CNT_W=4, FRAME_LEN=20 for saturation.
module tb_frame_mismatch_counter;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, in_last;
    logic [7:0] in_a, in_b;
    logic       out_valid, out_ready, out_all_equal;
    logic [7:0] out_pairs, out_mismatch;
    logic [11:0] out_bit_errs;

    logic       in_valid2, in_ready2, in_last2;
    logic [7:0] in_a2, in_b2;
    logic       out_valid2, out_ready2, out_all_equal2;
    logic [3:0] out_pairs2, out_mismatch2;
    logic [11:0] out_bit_errs2;

    int n_checks = 0;
    int n_fail   = 0;

    frame_mismatch_counter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pairs     (out_pairs),
        .out_mismatch  (out_mismatch),
        .out_bit_errs  (out_bit_errs),
        .out_all_equal (out_all_equal)
    );

    frame_mismatch_counter #(
        .WIDTH     (8),
        .FRAME_LEN (20),
        .CNT_W     (4),
        .ERR_W     (12)
    ) dut_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid2),
        .in_ready      (in_ready2),
        .in_a          (in_a2),
        .in_b          (in_b2),
        .in_last       (in_last2),
        .out_valid     (out_valid2),
        .out_ready     (out_ready2),
        .out_pairs     (out_pairs2),
        .out_mismatch  (out_mismatch2),
        .out_bit_errs  (out_bit_errs2),
        .out_all_equal (out_all_equal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a,
                        input logic [7:0] b,
                        input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_last2   = 1'b0;
        in_a2      = '0;
        in_b2      = '0;
        out_ready2 = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_pairs", 32'(out_pairs), 32'd0);
        check("rst_bit_errs", 32'(out_bit_errs), 32'd0);
        check("rst_all_equal", 32'(out_all_equal), 32'd1);
        rst_n = 1'b1;
        tick();

        // Single unequal pair with last
        send(8'h05, 8'h06, 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_pairs", 32'(out_pairs), 32'd1);
        check("t1_mism", 32'(out_mismatch), 32'd1);
        check("t1_errs", 32'(out_bit_errs), 32'd2);
        check("t1_all_eq", 32'(out_all_equal), 32'd0);
        drain();
        check("t1_drained", 32'(out_valid), 32'd0);
        check("t1_cleared", 32'(out_pairs), 32'd0);
        check("t1_ready_back", 32'(in_ready), 32'd1);

        // Full-length frame of equal pairs, back to back
        in_valid = 1'b1;
        in_a     = 8'hA5;
        in_b     = 8'hA5;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 14) check("t2_not_yet", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_pairs", 32'(out_pairs), 32'd16);
        check("t2_mism", 32'(out_mismatch), 32'd0);
        check("t2_errs", 32'(out_bit_errs), 32'd0);
        check("t2_all_eq", 32'(out_all_equal), 32'd1);
        drain();

        // Backpressure: record held stable, input blocked
        send(8'h00, 8'hFF, 1'b0);
        send(8'h0F, 8'h0F, 1'b1);
        in_valid = 1'b1;
        in_a     = 8'h12;
        in_b     = 8'h34;
        for (int i = 0; i < 5; i++) begin
            check("t3_valid", 32'(out_valid), 32'd1);
            check("t3_in_ready", 32'(in_ready), 32'd0);
            check("t3_pairs", 32'(out_pairs), 32'd2);
            check("t3_mism", 32'(out_mismatch), 32'd1);
            check("t3_errs", 32'(out_bit_errs), 32'd8);
            tick();
        end
        in_valid = 1'b0;
        drain();
        check("t3_ready_back", 32'(in_ready), 32'd1);
        check("t3_valid_low", 32'(out_valid), 32'd0);
        check("t3_cleared", 32'(out_bit_errs), 32'd0);

        // Saturating counters, frame still closes at 20
        in_valid2 = 1'b1;
        in_a2     = 8'h00;
        in_b2     = 8'h01;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 18) begin
                check("t4_not_yet", 32'(out_valid2), 32'd0);
                check("t4_sat_mid", 32'(out_pairs2), 32'd15);
            end
        end
        in_valid2 = 1'b0;
        check("t4_valid", 32'(out_valid2), 32'd1);
        check("t4_pairs", 32'(out_pairs2), 32'd15);
        check("t4_mism", 32'(out_mismatch2), 32'd15);
        check("t4_errs", 32'(out_bit_errs2), 32'd20);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        check("t4_drained", 32'(out_valid2), 32'd0);

        // Async reset mid-frame
        send(8'h01, 8'h00, 1'b0);
        send(8'h01, 8'h00, 1'b0);
        send(8'h01, 8'h00, 1'b0);
        check("t5_partial", 32'(out_pairs), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_pairs", 32'(out_pairs), 32'd0);
        check("t5_rst_mism", 32'(out_mismatch), 32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        send(8'h00, 8'h00, 1'b1);
        check("t5_new_valid", 32'(out_valid), 32'd1);
        check("t5_new_pairs", 32'(out_pairs), 32'd1);
        drain();

        // Gapped valid; in_last on idle cycles must be ignored
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_a     = (i % 2 == 0) ? 8'(i) : 8'hFF;
            in_b     = 8'h00;
            in_last  = (i % 2 == 1) || (i == 6);
            tick();
            if (i == 5) check("t6_not_yet", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_pairs", 32'(out_pairs), 32'd4);
        check("t6_mism", 32'(out_mismatch), 32'd3);
        check("t6_errs", 32'(out_bit_errs), 32'd4);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
